// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM BIST sequencer: FSM state encoding and the address-derived test pattern.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_WAIT,
        DONE
    } state_t;

    // Pattern is the address itself; the caller zero-extends or truncates to the data width.
    function automatic logic [31:0] pat(input logic [31:0] a, input logic inv);
        return inv ? ~a : a;
    endfunction

endpackage

// File: rtl/ram_bist_pattern.sv
// Combinational pattern generator: address (optionally inverted) mapped onto the RAM data width.
module ram_bist_pattern #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              inv,
    output logic [DATA_W-1:0] data
);
    import ram_bist_pkg::*;

    assign data = DATA_W'(pat(32'(addr), inv));

endmodule

// File: rtl/ram_bist_ctrl.sv
// Purpose: RAM BIST sequencer - writes address pattern, reads back, compares; RAM_BIST_INV_PASS_EN adds an inverted pass.
// Latency: start edge to done = 1 + DEPTH*WR_HOLD + DEPTH*(RD_LAT+1) cycles per pass.
// Backpressure: none; start is ignored while busy, the RAM is assumed always ready.
module ram_bist_ctrl #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 8,
    parameter int WR_HOLD = 2,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              mem_set,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    import ram_bist_pkg::*;

    localparam int CNT_MAX = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  WR_END  = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0]  LAT_END = CNT_W'(RD_LAT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              done_n, pass_n;
    logic [ADDR_W-1:0] fail_addr_n;
    logic              inv;
    logic              cmp_now;
    logic              mismatch;
    logic [DATA_W-1:0] pat_dat;

    ram_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .addr (addr),
        .inv  (inv),
        .data (pat_dat)
    );

`ifdef RAM_BIST_INV_PASS_EN
    logic inv_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inv <= 1'b0;
        else     inv <= inv_n;
    end
`else
    assign inv = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            cnt       <= cnt_n;
            done      <= done_n;
            pass      <= pass_n;
            fail_addr <= fail_addr_n;
        end
    end

    // Read data is judged on the last cycle of the read latency window (RD_ADDR itself when RD_LAT=0).
    assign cmp_now  = ((state == RD_ADDR) && (RD_LAT == 0)) ||
                      ((state == RD_WAIT) && (cnt == LAT_END));
    assign mismatch = (mem_data_out != pat_dat);

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        cnt_n       = cnt;
        done_n      = done;
        pass_n      = pass;
        fail_addr_n = fail_addr;
`ifdef RAM_BIST_INV_PASS_EN
        inv_n       = inv;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = WRITE;
                    addr_n      = '0;
                    cnt_n       = '0;
                    done_n      = 1'b0;
                    pass_n      = 1'b0;
                    fail_addr_n = '0;
`ifdef RAM_BIST_INV_PASS_EN
                    inv_n       = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (cnt == WR_END) begin
                    cnt_n = '0;
                    if (addr == LAST) begin
                        addr_n  = '0;
                        state_n = RD_ADDR;
                    end else begin
                        addr_n = addr + ADDR_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RD_ADDR: begin
                if (RD_LAT != 0) begin
                    state_n = RD_WAIT;
                    cnt_n   = '0;
                end
            end
            RD_WAIT: begin
                if (!cmp_now) cnt_n = cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase

        if (cmp_now) begin
            if (mismatch) begin
                fail_addr_n = addr;
                pass_n      = 1'b0;
                done_n      = 1'b1;
                state_n     = DONE;
            end else if (addr == LAST) begin
`ifdef RAM_BIST_INV_PASS_EN
                if (!inv) begin
                    inv_n   = 1'b1;
                    addr_n  = '0;
                    cnt_n   = '0;
                    state_n = WRITE;
                end else begin
                    pass_n  = 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
`else
                pass_n  = 1'b1;
                done_n  = 1'b1;
                state_n = DONE;
`endif
            end else begin
                addr_n  = addr + ADDR_W'(1);
                state_n = RD_ADDR;
            end
        end
    end

    assign busy        = (state == WRITE) || (state == RD_ADDR) || (state == RD_WAIT);
    assign mem_set     = busy;
    assign mem_wr      = (state == WRITE);
    assign mem_addr    = busy ? addr : '0;
    assign mem_data_in = mem_wr ? pat_dat : '0;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with injectable stuck bits, write scoreboard, vector table.
module tb_ram_bist_ctrl;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 8;
    localparam int WR_HOLD = 2;
    localparam int RD_LAT  = 1;
`ifdef RAM_BIST_INV_PASS_EN
    localparam int INV = 1;
`else
    localparam int INV = 0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic              mem_set;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    ram_bist_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .WR_HOLD (WR_HOLD),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .mem_set      (mem_set),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: registered read (latency 1), stuck-bit fault on one address
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    bit f_en;
    int f_addr, f_bit;
    bit f_val;

    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] m;
        m = DATA_W'(1) << f_bit;
        if (f_en && (int'(a) == f_addr)) return f_val ? (d | m) : (d & ~m);
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_set && mem_wr) ram[mem_addr] <= stored(mem_addr, mem_data_in);
        mem_data_out <= ram[mem_addr];
    end

    // Scoreboard: one expected {addr,data} entry per write cycle
    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    int max_rd;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr) begin
                if (exp_q.size() == 0) chk("wr_unexpected", {mem_addr, mem_data_in}, '1);
                else chk("wr_seq", {mem_addr, mem_data_in}, exp_q.pop_front());
            end
            if (busy && !mem_wr && (int'(mem_addr) > max_rd)) max_rd = int'(mem_addr);
        end
    end

    task automatic push_writes(input int passes);
        logic [DATA_W-1:0] d;
        for (int p = 0; p < passes; p++)
            for (int a = 0; a < DEPTH; a++) begin
                d = DATA_W'(a);
                if (p == 1) d = ~d;
                for (int h = 0; h < WR_HOLD; h++) exp_q.push_back({ADDR_W'(a), d});
            end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_fail_addr"}, fail_addr, 0);
        chk({tag, "_mem_set"}, mem_set, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data_in"}, mem_data_in, 0);
    endtask

    typedef struct {
        bit f_en;
        int f_addr;
        int f_bit;
        bit f_val;
        bit e_pass;
        int e_fail;
        int e_cyc;
        int e_maxrd;
        int passes;
    } vec_t;

    vec_t vt [6];

    // Edge count includes the edge that samples start as edge 1.
    function automatic int cyc_fail(input int pass_idx, input int fa);
        return 1 + (pass_idx + 1) * DEPTH * WR_HOLD + pass_idx * DEPTH * (RD_LAT + 1) + (fa + 1) * (RD_LAT + 1);
    endfunction

    function automatic int cyc_good();
        return 1 + (INV + 1) * DEPTH * (WR_HOLD + RD_LAT + 1);
    endfunction

    // mode 0: one-cycle start pulse; 1: start held high; 2: start re-pulsed while busy
    task automatic run(input int vi, input int mode, input string tag);
        int n;
        bit got;
        f_en   = vt[vi].f_en;
        f_addr = vt[vi].f_addr;
        f_bit  = vt[vi].f_bit;
        f_val  = vt[vi].f_val;
        max_rd = -1;
        push_writes(vt[vi].passes);
        @(negedge clk);
        start = 1'b1;
        n   = 0;
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) chk({tag, "_busy_after_start"}, busy, 1);
            if (done) got = 1;
            else begin
                case (mode)
                    1:       start = 1'b1;
                    2:       start = ((n % 4) == 0);
                    default: start = 1'b0;
                endcase
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_cycles"}, n, vt[vi].e_cyc);
        chk({tag, "_pass"}, pass, vt[vi].e_pass);
        if (!vt[vi].e_pass) chk({tag, "_fail_addr"}, fail_addr, vt[vi].e_fail);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_mem_set_end"}, mem_set, 0);
        chk({tag, "_max_rd_addr"}, max_rd, vt[vi].e_maxrd);
        chk({tag, "_wr_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        chk({tag, "_done_held"}, done, 1);
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 0, 1, 0, cyc_good(), 7, INV + 1};
        vt[1] = '{1, 5, 0, 0, 0, 5, cyc_fail(0, 5), 5, 1};
        vt[2] = '{1, 0, 3, 1, 0, 0, cyc_fail(0, 0), 0, 1};
        vt[3] = '{1, 7, 2, 0, 0, 7, cyc_fail(0, 7), 7, 1};
        // Faults invisible to the true pattern, caught only by the inverted pass
        if (INV != 0) begin
            vt[4] = '{1, 2, 0, 0, 0, 2, cyc_fail(1, 2), 7, 2};
            vt[5] = '{1, 6, 1, 1, 0, 6, cyc_fail(1, 6), 7, 2};
        end else begin
            vt[4] = '{1, 2, 0, 0, 1, 0, cyc_good(), 7, 1};
            vt[5] = '{1, 6, 1, 1, 1, 0, cyc_good(), 7, 1};
        end

        rst   = 1'b0;
        start = 1'b0;
        f_en  = 0;
        #1 rst = 1'b1;
        #1 chk_zero("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run(i, 0, $sformatf("vec%0d", i));

        run(0, 1, "start_held");
        run(0, 2, "start_repulse");

        // Reset in the middle of the write phase at address 3
        f_en = 0;
        push_writes(INV + 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int k = 0; k < 100 && !hit; k++) begin
                @(negedge clk);
                if (mem_wr && mem_addr == 3) hit = 1;
            end
            chk("mid_wr_addr3_reached", hit, 1);
        end
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        run(0, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
